// File: rtl/seq_bcd_decoder.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// optional two's-complement input, overflow flag and leading-zero blanking mask.
//
// state | meaning
// IDLE  | waiting for start; results hold last conversion
// SHIFT | one double-dabble iteration per edge
// DONE  | one-cycle result-valid pulse
module seq_bcd_decoder #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binary,
  input  logic                  signed_mode,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  negative,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0]     LAST      = CW'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  mag;
  logic [BW-1:0]     acc;
  logic [CW-1:0]     cnt;
  logic              ovf;
  logic              neg_reg;
  logic [BW-1:0]     acc_adj;
  logic [BW-1:0]     acc_shift;
  logic              carry;
  logic              zero_above;
  logic [DIGITS-1:0] blank_next;
  logic              is_neg;

  assign is_neg = signed_mode & binary[WIDTH-1];
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction, then shift; the top accumulator bit is the overflow carry.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
    carry      = acc_adj[BW-1];
    acc_shift  = {acc_adj[BW-2:0], mag[WIDTH-1]};
    zero_above = 1'b1;
    blank_next = '0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      zero_above    = zero_above & (acc_shift[4*d +: 4] == 4'd0);
      blank_next[d] = zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mag        <= '0;
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      neg_reg    <= 1'b0;
      bcd        <= '0;
      negative   <= 1'b0;
      overflow   <= 1'b0;
      blank_mask <= BLANK_RST;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            mag     <= is_neg ? (~binary + WIDTH'(1)) : binary;
            neg_reg <= is_neg;
            acc     <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          acc <= acc_shift;
          mag <= {mag[WIDTH-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          ovf <= ovf | carry;
          if (cnt == LAST) begin
            bcd        <= acc_shift;
            negative   <= neg_reg;
            overflow   <= ovf | carry;
            blank_mask <= blank_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bcd_decoder.sv
// Bench for seq_bcd_decoder: a 5-digit and a 4-digit instance share stimulus and
// are compared against a decimal-arithmetic reference model.
module tb_seq_bcd_decoder;

  logic        clk = 1'b0;
  logic        reset, start, signed_mode;
  logic [15:0] binary;
  logic        busy, done, negative, overflow;
  logic [19:0] bcd;
  logic [4:0]  blank_mask;
  logic        busy4, done4, negative4, overflow4;
  logic [15:0] bcd4;
  logic [3:0]  blank_mask4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_bcd_decoder #(.WIDTH(16), .DIGITS(5)) dut (
    .clk(clk), .reset(reset), .start(start), .binary(binary), .signed_mode(signed_mode),
    .busy(busy), .done(done), .bcd(bcd), .negative(negative), .overflow(overflow),
    .blank_mask(blank_mask));

  seq_bcd_decoder #(.WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .binary(binary), .signed_mode(signed_mode),
    .busy(busy4), .done(done4), .bcd(bcd4), .negative(negative4), .overflow(overflow4),
    .blank_mask(blank_mask4));

  // Reference: plain decimal arithmetic on the magnitude.
  function automatic void model(input logic [15:0] b, input logic sm, input int nd,
                                output logic [39:0] e_bcd, output logic e_neg,
                                output logic e_ovf, output logic [9:0] e_blank);
    longint mag, p, low, q;
    e_neg = sm && b[15];
    mag   = e_neg ? (longint'(65536) - longint'(b)) : longint'(b);
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    e_ovf = (mag >= p);
    low   = mag % p;
    e_bcd = '0;
    e_blank = '0;
    q = low;
    for (int i = 0; i < nd; i++) begin
      e_bcd[4*i +: 4] = 4'(q % 10);
      e_blank[i]      = (i != 0) && (q == 0);
      q = q / 10;
    end
  endfunction

  // Starts one conversion, scrambles inputs while busy, returns edges to done
  // (counting the accepting edge as 1) or -1 on timeout.
  task automatic do_conv(input logic [15:0] b, input logic sm, output int n);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    binary = b; signed_mode = sm; start = 1'b1;
    @(posedge clk);
    n = 1;
    #1;
    start = 1'b0;
    while (!done && n < 40) begin
      binary      = 16'($urandom);
      signed_mode = 1'($urandom_range(0, 1));
      start       = 1'($urandom_range(0, 1));
      @(posedge clk);
      n++;
      #1;
    end
    start = 1'b0;
    if (!done) n = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; binary = '0; signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_busy_done got %b%b exp 00", busy, done);
    end
    checks++;
    if (bcd !== 20'h0 || negative !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL reset_result got bcd %h neg %b ovf %b exp 0 0 0", bcd, negative, overflow);
    end
    checks++;
    if (blank_mask !== 5'b11110 || blank_mask4 !== 4'b1110) begin
      errors++; $display("FAIL reset_blank got %b %b exp 11110 1110", blank_mask, blank_mask4);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unsigned_max();
    int n;
    do_conv(16'hFFFF, 1'b0, n);
    checks++;
    if (n !== 17) begin errors++; $display("FAIL umax_latency got %0d exp 17", n); end
    checks++;
    if (bcd !== 20'h65535 || overflow !== 1'b0 || negative !== 1'b0 || blank_mask !== 5'b00000) begin
      errors++;
      $display("FAIL umax_result got %h %b %b %b exp 65535 0 0 00000", bcd, overflow, negative, blank_mask);
    end
  endtask

  task automatic test_signed();
    int n;
    do_conv(16'hFFF6, 1'b1, n);
    checks++;
    if (bcd !== 20'h00010 || negative !== 1'b1 || blank_mask !== 5'b11100) begin
      errors++; $display("FAIL signed_m10 got %h %b %b exp 00010 1 11100", bcd, negative, blank_mask);
    end
    do_conv(16'h8000, 1'b1, n);
    checks++;
    if (bcd !== 20'h32768 || negative !== 1'b1 || overflow !== 1'b0) begin
      errors++; $display("FAIL signed_min got %h %b %b exp 32768 1 0", bcd, negative, overflow);
    end
    do_conv(16'h0000, 1'b1, n);
    checks++;
    if (bcd !== 20'h0 || negative !== 1'b0 || blank_mask !== 5'b11110) begin
      errors++; $display("FAIL signed_zero got %h %b %b exp 0 0 11110", bcd, negative, blank_mask);
    end
  endtask

  task automatic test_overflow();
    int n;
    do_conv(16'd12345, 1'b0, n);
    checks++;
    if (bcd4 !== 16'h2345 || overflow4 !== 1'b1 || blank_mask4 !== 4'b0000) begin
      errors++; $display("FAIL ovf_12345 got %h %b %b exp 2345 1 0000", bcd4, overflow4, blank_mask4);
    end
    do_conv(16'd9999, 1'b0, n);
    checks++;
    if (bcd4 !== 16'h9999 || overflow4 !== 1'b0) begin
      errors++; $display("FAIL ovf_9999 got %h %b exp 9999 0", bcd4, overflow4);
    end
  endtask

  task automatic test_start_during_busy();
    int bc, dc;
    logic [19:0] got;
    bc = 0; dc = 0; got = '0;
    @(negedge clk);
    @(negedge clk);
    binary = 16'd100; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (busy) bc++;
      if (done) begin dc++; got = bcd; end
      if (c == 5) begin start = 1'b1; binary = 16'd200; end
      else start = 1'b0;
      @(posedge clk);
      #1;
    end
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL busy_start_pulses got %0d exp 1", dc); end
    checks++;
    if (bc !== 16) begin errors++; $display("FAIL busy_cycles got %0d exp 16", bc); end
    checks++;
    if (got !== 20'h00100) begin errors++; $display("FAIL busy_start_result got %h exp 00100", got); end
  endtask

  task automatic test_reset_mid();
    int dc, n;
    dc = 0;
    @(negedge clk);
    @(negedge clk);
    binary = 16'd4321; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h0 || blank_mask !== 5'b11110) begin
      errors++; $display("FAIL midreset_state got %b %b %h %b exp 0 0 0 11110", busy, done, bcd, blank_mask);
    end
    for (int c = 0; c < 25; c++) begin
      if (done) dc++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (dc !== 0) begin errors++; $display("FAIL midreset_no_done got %0d exp 0", dc); end
    do_conv(16'h0000, 1'b0, n);
    checks++;
    if (n !== 17 || bcd !== 20'h0 || blank_mask !== 5'b11110 || negative !== 1'b0) begin
      errors++; $display("FAIL midreset_fresh got n %0d %h %b %b exp 17 0 11110 0", n, bcd, blank_mask, negative);
    end
  endtask

  task automatic test_random();
    logic [15:0] corners [6];
    logic [15:0] b;
    logic        sm;
    logic [39:0] e_bcd, e_bcd4;
    logic        e_neg, e_ovf, e_neg4, e_ovf4;
    logic [9:0]  e_blank, e_blank4;
    int n;
    corners = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'd9999, 16'd10000};
    for (int k = 0; k < 40; k++) begin
      b  = (k < 6) ? corners[k] : 16'($urandom);
      sm = 1'($urandom_range(0, 1));
      model(b, sm, 5, e_bcd, e_neg, e_ovf, e_blank);
      model(b, sm, 4, e_bcd4, e_neg4, e_ovf4, e_blank4);
      do_conv(b, sm, n);
      checks++;
      if (n !== 17) begin errors++; $display("FAIL rnd_latency in %h got %0d exp 17", b, n); end
      checks++;
      if (bcd !== e_bcd[19:0] || negative !== e_neg || overflow !== e_ovf || blank_mask !== e_blank[4:0]) begin
        errors++;
        $display("FAIL rnd_d5 in %h sm %b got %h %b %b %b exp %h %b %b %b", b, sm,
                 bcd, negative, overflow, blank_mask, e_bcd[19:0], e_neg, e_ovf, e_blank[4:0]);
      end
      checks++;
      if (bcd4 !== e_bcd4[15:0] || negative4 !== e_neg4 || overflow4 !== e_ovf4 || blank_mask4 !== e_blank4[3:0]) begin
        errors++;
        $display("FAIL rnd_d4 in %h sm %b got %h %b %b %b exp %h %b %b %b", b, sm,
                 bcd4, negative4, overflow4, blank_mask4, e_bcd4[15:0], e_neg4, e_ovf4, e_blank4[3:0]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || bcd !== e_bcd[19:0] || negative !== e_neg) begin
        errors++; $display("FAIL rnd_hold got done %b bcd %h exp 0 %h", done, bcd, e_bcd[19:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_overflow();
    test_start_during_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_bcd_decoder.md
SEQ_BCD_DECODER -- requirements
Module: seq_bcd_decoder

Parameters
REQ-001 WIDTH, 16, binary input width; legal range 2..32.
REQ-002 DIGITS, 5, number of BCD output digits; legal range 1..10.

Interface
REQ-003 clk  input  1  clock, positive-edge; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  conversion request; sampled only in IDLE.
REQ-006 binary  input  WIDTH  value to convert; sampled on the edge that accepts start.
REQ-007 signed_mode  input  1  1 = treat binary as two's complement; sampled with binary.
REQ-008 busy  output  1  high while a conversion is in progress (SHIFT state).
REQ-009 done  output  1  one-cycle pulse; result outputs are valid from this cycle onward.
REQ-010 bcd  output  4*DIGITS  result digits; digit i occupies bits [4i+3:4i], with digit 0 as the ones digit.
REQ-011 negative  output  1  result sign (1 = binary was negative in signed mode).
REQ-012 overflow  output  1  magnitude >= 10^DIGITS; bcd then holds the low DIGITS digits.
REQ-013 blank_mask  output  DIGITS  bit i = 1 when digit i and all higher digits are zero (leading-zero blanking); bit 0 is always 0.

Function
REQ-014 The block SHALL be a three-state FSM: IDLE, SHIFT, DONE; all outputs SHALL be registered or decoded from state only.
REQ-015 IDLE SHALL go to SHIFT on any edge with start=1 and SHALL otherwise remain in IDLE.
- On that edge: magnitude := (signed_mode & binary[WIDTH-1]) ? -binary : binary, as a WIDTH-bit unsigned value.
- Also on that edge: neg_reg := signed_mode & binary[WIDTH-1]; digit accumulator := 0; ovf := 0; iteration counter := 0.
REQ-016 Each SHIFT edge SHALL perform exactly one double-dabble iteration:
- Every digit >= 5 gets +3.
- Then {digits, magnitude} shifts left by 1.
- Counter increments.
REQ-017 Any 1 shifted out of digit DIGITS-1 bit 3 SHALL set ovf (sticky for the conversion).
REQ-018 SHIFT SHALL transition to DONE on the edge performing iteration WIDTH (counter == WIDTH-1).
- On that same edge, bcd, negative and overflow SHALL be loaded with the final values, including that edge's carry-out.
- On that same edge, blank_mask SHALL be loaded, computed from the final digits.
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally; done = (state == DONE) and busy = (state == SHIFT).
REQ-020 Latency: done SHALL be high in the cycle following the (WIDTH+1)th rising edge counted from, and including, the edge that accepts start.
- Minimum start-to-start spacing is WIDTH+2 cycles.
REQ-021 start asserted in SHIFT or DONE SHALL be ignored and not queued; binary and signed_mode changes during SHIFT SHALL not affect the result.
REQ-022 bcd, negative, overflow and blank_mask SHALL hold their last values until the next DONE entry.
REQ-023 Signed input -2^(WIDTH-1) SHALL convert to magnitude 2^(WIDTH-1) with negative=1.
REQ-024 Zero SHALL convert to bcd=0 and negative=0 in both modes.
REQ-025 Internal counter width SHALL be $clog2(WIDTH) bits minimum; no combinational path from inputs to outputs.

Reset
REQ-026 reset=1 on an edge SHALL force state IDLE, busy=0, done=0, bcd=0, negative=0, overflow=0, and blank_mask = all ones except bit 0.
REQ-027 Reset SHALL take priority over start and over an in-progress conversion; the aborted conversion SHALL produce no done pulse.

Verification (WIDTH=16, DIGITS=5 unless stated)
REQ-028 Unsigned maximum: start, binary=0xFFFF, signed_mode=0 -> done exactly 17 edges after the start edge; bcd=0x65535, overflow=0, negative=0, blank_mask=00000.
REQ-029 Signed negative: binary=0xFFF6, signed_mode=1 -> bcd=0x00010, negative=1, blank_mask=11100; then binary=0x8000 signed -> bcd=0x32768, negative=1.
REQ-030 Overflow with WIDTH=16, DIGITS=4: binary=12345 -> bcd=0x2345, overflow=1; then binary=9999 -> overflow=0.
REQ-031 Start during busy: start 100, then pulse start with 200 at iteration 5 -> a single done pulse, bcd=0x00100; busy high for exactly 16 cycles.
REQ-032 Reset mid-operation: reset at iteration 8 -> next cycle busy=0, done=0, bcd=0, blank_mask=11110, and no done pulse follows; a fresh start with 0 -> bcd=0, blank_mask=11110.
